priority_decoder: RTL and testbench

PRIORITY_DECODER -- requirements
Module: priority_decoder

---
 rtl/priority_decoder_pkg.sv | 13 +
 rtl/priority_decoder_onehot_dec.sv | 12 +
 rtl/priority_decoder.sv | 90 +++++++++
 tb/tb_priority_decoder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/priority_decoder_pkg.sv
// Shared defaults and FSM encoding for the priority decoder and its sub-blocks.
package priority_decoder_pkg;

   localparam int IDX_W_DEF = 3;
   localparam int OUT_W_DEF = 2**IDX_W_DEF;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/priority_decoder_onehot_dec.sv
// Pure combinational binary-index to one-hot conversion; every code maps to one bit.
module onehot_dec #(
   parameter int IDX_W = 3,
   parameter int OUT_W = 2**IDX_W
) (
   input  logic [IDX_W-1:0] idx,
   output logic [OUT_W-1:0] onehot
);

   assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/priority_decoder.sv
// Index-to-one-hot decoder behind a 2-entry in-order skid buffer, plus a sticky
// record of every one-hot word accepted since the last clear.
module priority_decoder
   import priority_decoder_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int OUT_W = 2**IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             mask_clr,
   output logic [OUT_W-1:0] seen_mask
);

   state_t           state;
   logic [OUT_W-1:0] head;
   logic [OUT_W-1:0] skid;
   logic [OUT_W-1:0] dec_word;
   logic             push;
   logic             pop;

   // One decoder feeds both the buffered data path and the sticky mask.
   onehot_dec #(
      .IDX_W (IDX_W),
      .OUT_W (OUT_W)
   ) u_dec (
      .idx    (in_idx),
      .onehot (dec_word)
   );

   // Handshake flags are pure decodes of registered state, so in_ready never
   // depends combinationally on out_ready.
   assign in_ready   = (state != FULL);
   assign out_valid  = (state != EMPTY);
   assign out_onehot = head;
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (push) begin
                  head  <= dec_word;
                  state <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head <= dec_word;
               end else if (push) begin
                  skid  <= dec_word;
                  state <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head  <= skid;
                  state <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // A clear coinciding with an accept keeps only the newly accepted bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_mask <= '0;
      end else if (mask_clr) begin
         seen_mask <= push ? dec_word : '0;
      end else if (push) begin
         seen_mask <= seen_mask | dec_word;
      end
   end

endmodule

// File: tb/tb_priority_decoder.sv
// Directed and randomized checks of priority_decoder against a queue-based reference.
module tb_priority_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] in_idx = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_onehot;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       mask_clr = 1'b0;
   logic [7:0] seen_mask;

   int total  = 0;
   int passed = 0;

   // Reference: FIFO of accepted indices (capacity 2) and the set of seen indices.
   int         q[$];
   logic [7:0] ref_mask = '0;

   priority_decoder #(.IDX_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_idx     (in_idx),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_onehot (out_onehot),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .mask_clr   (mask_clr),
      .seen_mask  (seen_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < 2));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk({tag, "_onehot"}, 32'(out_onehot), 32'(1) << q[0]);
      chk({tag, "_mask"}, 32'(seen_mask), 32'(ref_mask));
   endtask

   // Drive one cycle of inputs, advance the reference, then check after the edge.
   task automatic cycle(input logic iv, input int idx, input logic ordy,
                        input logic mc, input string tag);
      logic       acc, rem, stalled;
      logic [7:0] held;
      in_valid  = iv;
      in_idx    = 3'(idx);
      out_ready = ordy;
      mask_clr  = mc;
      acc       = iv && (q.size() < 2);
      rem       = ordy && (q.size() > 0);
      stalled   = (q.size() > 0) && !ordy;
      held      = out_onehot;
      @(posedge clk);
      if (rem) void'(q.pop_front());
      if (acc) q.push_back(idx & 7);
      if (mc) ref_mask = acc ? 8'(1 << (idx & 7)) : 8'h00;
      else if (acc) ref_mask = ref_mask | 8'(1 << (idx & 7));
      #1;
      chk_model(tag);
      if (stalled) chk({tag, "_stable"}, 32'(out_onehot), 32'(held));
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_onehot", 32'(out_onehot), 32'd0);
      chk("rst_mask", 32'(seen_mask), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single transfer, 1-cycle latency
      cycle(1'b1, 5, 1'b1, 1'b0, "lat_push");
      chk("lat_oh", 32'(out_onehot), 32'h20);
      chk("lat_vld", 32'(out_valid), 32'd1);
      cycle(1'b0, 0, 1'b1, 1'b0, "lat_pop");
      chk("lat_empty", 32'(out_valid), 32'd0);

      // Backpressure fills the skid, then drains in order
      cycle(1'b1, 3, 1'b0, 1'b0, "bp_p3");
      cycle(1'b1, 6, 1'b0, 1'b0, "bp_p6");
      chk("bp_full", 32'(in_ready), 32'd0);
      chk("bp_first", 32'(out_onehot), 32'h08);
      cycle(1'b0, 0, 1'b1, 1'b0, "bp_d1");
      chk("bp_second", 32'(out_onehot), 32'h40);
      chk("bp_ready", 32'(in_ready), 32'd1);
      cycle(1'b0, 0, 1'b1, 1'b0, "bp_d2");

      // Stream every code back-to-back after clearing the mask
      cycle(1'b0, 0, 1'b1, 1'b1, "clr");
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1, k, 1'b1, 1'b0, "stream");
         chk("stream_oh", 32'(out_onehot), 32'(1) << k);
      end
      cycle(1'b0, 0, 1'b1, 1'b0, "stream_end");
      chk("stream_mask", 32'(seen_mask), 32'hFF);

      // Clear coinciding with an accept keeps the new bit
      cycle(1'b1, 2, 1'b1, 1'b1, "clr_acc");
      chk("clr_acc_mask", 32'(seen_mask), 32'h04);
      cycle(1'b0, 0, 1'b1, 1'b0, "clr_acc_drain");

      // Asynchronous reset while full
      cycle(1'b1, 1, 1'b0, 1'b0, "ar_p1");
      cycle(1'b1, 4, 1'b0, 1'b0, "ar_p4");
      chk("ar_full", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_vld", 32'(out_valid), 32'd0);
      chk("ar_mask", 32'(seen_mask), 32'd0);
      chk("ar_rdy", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      q.delete();
      ref_mask = '0;
      for (int k = 0; k < 3; k++) cycle(1'b0, 0, 1'b1, 1'b0, "ar_after");

      // Randomized traffic against the reference
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rnd");
      end
      for (int n = 0; n < 4 && q.size() > 0; n++) cycle(1'b0, 0, 1'b1, 1'b0, "drain");
      chk("drain_empty", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
